// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the execute-stage ALU share arbiter:
// ALU operation encoding, response buffer states and width helpers.
package alu_share_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ADD     = 4'd0,
    SUB     = 4'd1,
    LOGIAND = 4'd2,
    LOGIOR  = 4'd3,
    LOGIXOR = 4'd4,
    SLL_OP  = 4'd5,
    SRL_OP  = 4'd6,
    SRA_OP  = 4'd7,
    SLT_OP  = 4'd8
  } alu_op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  // Index width that stays at least one bit wide.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_grant_picker.sv
// Combinational grant picker: starved requesters first (lowest index),
// then requester 0 under static priority, then round-robin from the pointer.
module alu_share_arbiter_rr_grant_picker
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               prio0_i,
  input  logic [NUM_REQ-1:0] starve_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_any_o
);

  logic [NUM_REQ-1:0] starved;

  assign starved = valid_i & starve_i;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    if (|starved) begin
      // Downward scan so the lowest qualifying index is written last.
      for (int i = NUM_REQ-1; i >= 0; i--) begin
        if (starved[i]) begin
          gnt_idx_o = IDX_W'(i);
          gnt_any_o = 1'b1;
        end
      end
    end else if (prio0_i && valid_i[0]) begin
      gnt_idx_o = '0;
      gnt_any_o = 1'b1;
    end else begin
      for (int k = NUM_REQ-1; k >= 0; k--) begin
        if (valid_i[(int'(ptr_i) + k) % NUM_REQ]) begin
          gnt_idx_o = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
          gnt_any_o = 1'b1;
        end
      end
    end
    if (gnt_any_o) gnt_oh_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one execute-stage ALU among NUM_REQ requesters and returns each
// result through a one-entry response buffer owned by the winning requester.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int TAG_W      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              prio0_i,
  input  logic                              flush_i,
  input  logic [NUM_REQ-1:0]                reqValid_i,
  output logic [NUM_REQ-1:0]                reqReady_o,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    reqIn1_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    reqIn2_i,
  input  logic [NUM_REQ-1:0][OP_W-1:0]      reqOp_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]     reqTag_i,
  output logic [DATA_W-1:0]                 aluIn1_o,
  output logic [DATA_W-1:0]                 aluIn2_o,
  output logic [OP_W-1:0]                   aluOperation_o,
  input  logic [DATA_W-1:0]                 aluOutput_i,
  input  logic                              aluZero_i,
  output logic [NUM_REQ-1:0]                rspValid_o,
  input  logic [NUM_REQ-1:0]                rspReady_i,
  output logic [DATA_W-1:0]                 rspData_o,
  output logic                              rspZero_o,
  output logic [TAG_W-1:0]                  rspTag_o
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  buf_state_e                      state_q, state_d;
  logic [IDX_W-1:0]                own_q, own_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic [DATA_W-1:0]               data_q, data_d;
  logic                            zero_q, zero_d;
  logic [TAG_W-1:0]                tag_q, tag_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]   starve_q, starve_d;

  logic [NUM_REQ-1:0] starve_flag;
  logic [NUM_REQ-1:0] cand_valid;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               can_accept;
  logic               grant_en;

  // A held response frees the slot in the same cycle its owner drains it.
  assign can_accept = (state_q == EMPTY) || rspReady_i[own_q];
  assign grant_en   = can_accept && !flush_i;
  assign cand_valid = reqValid_i & {NUM_REQ{grant_en}};

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      starve_flag[i] = (starve_q[i] == CNT_W'(STARVE_MAX));
    end
  end

  alu_share_arbiter_rr_grant_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid_i   (cand_valid),
    .ptr_i     (ptr_q),
    .prio0_i   (prio0_i),
    .starve_i  (starve_flag),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // Flush wins over both a refill and a drain.
  always_comb begin
    state_d = state_q;
    if (flush_i)                                 state_d = EMPTY;
    else if (gnt_any)                            state_d = FULL;
    else if (state_q == FULL && rspReady_i[own_q]) state_d = EMPTY;
  end

  always_comb begin
    reqReady_o     = gnt_oh;
    aluIn1_o       = '0;
    aluIn2_o       = '0;
    aluOperation_o = '0;
    if (gnt_any) begin
      aluIn1_o       = reqIn1_i[gnt_idx];
      aluIn2_o       = reqIn2_i[gnt_idx];
      aluOperation_o = reqOp_i[gnt_idx];
    end
    rspValid_o = '0;
    if (state_q == FULL) rspValid_o[own_q] = 1'b1;
  end

  always_comb begin
    own_d    = own_q;
    data_d   = data_q;
    zero_d   = zero_q;
    tag_d    = tag_q;
    ptr_d    = ptr_q;
    starve_d = starve_q;
    if (gnt_any) begin
      own_d  = gnt_idx;
      data_d = aluOutput_i;
      zero_d = aluZero_i;
      tag_d  = reqTag_i[gnt_idx];
      ptr_d  = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!reqValid_i[i] || gnt_oh[i])  starve_d[i] = '0;
      else if (!starve_flag[i])         starve_d[i] = starve_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      own_q    <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      tag_q    <= '0;
      ptr_q    <= '0;
      starve_q <= '0;
    end else begin
      own_q    <= own_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      tag_q    <= tag_d;
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
    end
  end

  assign rspData_o = data_q;
  assign rspZero_o = zero_q;
  assign rspTag_o  = tag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU in the loop;
// expected values are hand-computed per scenario.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int TW = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 prio0, flush;
  logic [NR-1:0]        reqValid, reqReady;
  logic [NR-1:0][31:0]  reqIn1, reqIn2;
  logic [NR-1:0][3:0]   reqOp;
  logic [NR-1:0][TW-1:0] reqTag;
  logic [31:0]          aluIn1, aluIn2, aluOutput;
  logic [3:0]           aluOperation;
  logic                 aluZero;
  logic [NR-1:0]        rspValid, rspReady;
  logic [31:0]          rspData;
  logic                 rspZero;
  logic [TW-1:0]        rspTag;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .STARVE_MAX(8)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .prio0_i        (prio0),
    .flush_i        (flush),
    .reqValid_i     (reqValid),
    .reqReady_o     (reqReady),
    .reqIn1_i       (reqIn1),
    .reqIn2_i       (reqIn2),
    .reqOp_i        (reqOp),
    .reqTag_i       (reqTag),
    .aluIn1_o       (aluIn1),
    .aluIn2_o       (aluIn2),
    .aluOperation_o (aluOperation),
    .aluOutput_i    (aluOutput),
    .aluZero_i      (aluZero),
    .rspValid_o     (rspValid),
    .rspReady_i     (rspReady),
    .rspData_o      (rspData),
    .rspZero_o      (rspZero),
    .rspTag_o       (rspTag)
  );

  // Behavioural ALU standing in for the execute-stage instance.
  always_comb begin
    aluOutput = '0;
    case (aluOperation)
      ADD:     aluOutput = aluIn1 + aluIn2;
      SUB:     aluOutput = aluIn1 - aluIn2;
      LOGIAND: aluOutput = aluIn1 & aluIn2;
      LOGIOR:  aluOutput = aluIn1 | aluIn2;
      LOGIXOR: aluOutput = aluIn1 ^ aluIn2;
      SLL_OP:  aluOutput = aluIn1 << aluIn2[4:0];
      SRL_OP:  aluOutput = aluIn1 >> aluIn2[4:0];
      SRA_OP:  aluOutput = $unsigned($signed(aluIn1) >>> aluIn2[4:0]);
      SLT_OP:  aluOutput = {31'd0, $signed(aluIn1) < $signed(aluIn2)};
      default: aluOutput = '0;
    endcase
  end
  assign aluZero = (aluOutput == 32'd0);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] tg);
    reqOp[r]    = op;
    reqIn1[r]   = a;
    reqIn2[r]   = b;
    reqTag[r]   = tg;
    reqValid[r] = 1'b1;
  endtask

  // Requester protocol: a pending request stays valid and stable until accepted.
  logic [NR-1:0]         pv = '0, prdy = '0;
  logic [NR-1:0][31:0]   p1, p2;
  logic [NR-1:0][TW-1:0] ptg;
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (!reset && pv[i] && !prdy[i]) begin
        check_eq("hold_valid", {31'd0, reqValid[i]}, 32'd1);
        check_eq("hold_in1", reqIn1[i], p1[i]);
        check_eq("hold_in2", reqIn2[i], p2[i]);
        check_eq("hold_tag", {28'd0, reqTag[i]}, {28'd0, ptg[i]});
      end
    end
    pv   = reqValid;
    prdy = reqReady;
    p1   = reqIn1;
    p2   = reqIn2;
    ptg  = reqTag;
  end

  logic [1:0] exp_g, prev_g;

  initial begin
    reset = 1'b1; prio0 = 1'b0; flush = 1'b0;
    reqValid = '0; rspReady = '0;
    reqIn1 = '0; reqIn2 = '0; reqOp = '0; reqTag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    #4;
    check_eq("idle_rspValid", rspValid, 0);
    check_eq("idle_aluOp", aluOperation, 0);
    check_eq("idle_aluIn1", aluIn1, 0);
    check_eq("idle_reqReady", reqReady, 0);
    check_eq("idle_rspData", rspData, 0);
    check_eq("idle_rspTag", rspTag, 0);
    next_cycle();

    // Single ADD from requester 0
    rspReady = 2'b11;
    set_req(0, ADD, 32'd5, 32'd7, 4'd3);
    #4;
    check_eq("single_reqReady", reqReady, 2'b01);
    check_eq("single_aluIn1", aluIn1, 5);
    check_eq("single_aluIn2", aluIn2, 7);
    check_eq("single_aluOp", aluOperation, ADD);
    next_cycle();
    reqValid[0] = 1'b0;
    #4;
    check_eq("single_rspValid", rspValid, 2'b01);
    check_eq("single_rspData", rspData, 12);
    check_eq("single_rspZero", rspZero, 0);
    check_eq("single_rspTag", rspTag, 3);
    check_eq("single_noGrant", reqReady, 0);
    next_cycle();

    // Round-robin contention; pointer sits at 1 after the grant to 0
    set_req(0, ADD, 32'd1, 32'd2, 4'd1);
    set_req(1, ADD, 32'd10, 32'd20, 4'd2);
    prev_g = 2'b00;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      #4;
      check_eq("rr_grant", reqReady, exp_g);
      if (i > 0) begin
        check_eq("rr_rspValid", rspValid, prev_g);
        check_eq("rr_rspData", rspData, (prev_g == 2'b01) ? 32'd3 : 32'd30);
      end
      prev_g = exp_g;
      next_cycle();
    end
    reqValid = '0;
    #4;
    check_eq("rr_last_rspValid", rspValid, 2'b01);
    check_eq("rr_last_rspData", rspData, 3);
    next_cycle();

    // Backpressure on requester 1
    rspReady = 2'b01;
    set_req(1, SUB, 32'd9, 32'd9, 4'd5);
    #4;
    check_eq("bp_grant", reqReady, 2'b10);
    next_cycle();
    reqValid[1] = 1'b0;
    set_req(0, ADD, 32'd4, 32'd4, 4'd6);
    for (int h = 0; h < 3; h++) begin
      #4;
      check_eq("bp_rspValid", rspValid, 2'b10);
      check_eq("bp_rspData", rspData, 0);
      check_eq("bp_rspZero", rspZero, 1);
      check_eq("bp_rspTag", rspTag, 5);
      check_eq("bp_reqReady", reqReady, 0);
      next_cycle();
    end
    rspReady = 2'b11;
    #4;
    check_eq("bp_accept", reqReady, 2'b01);
    check_eq("bp_drain_rspValid", rspValid, 2'b10);
    next_cycle();
    reqValid = '0;
    #4;
    check_eq("bp_next_rspValid", rspValid, 2'b01);
    check_eq("bp_next_rspData", rspData, 8);
    check_eq("bp_next_rspTag", rspTag, 6);
    next_cycle();

    // Starvation escalation under static priority for requester 0
    prio0 = 1'b1;
    set_req(0, ADD, 32'd1, 32'd1, 4'd0);
    set_req(1, ADD, 32'd2, 32'd2, 4'd1);
    for (int w = 1; w <= 10; w++) begin
      #4;
      check_eq("starve_grant", reqReady, (w == 9) ? 2'b10 : 2'b01);
      if (w == 10) begin
        check_eq("starve_rspValid", rspValid, 2'b10);
        check_eq("starve_rspData", rspData, 4);
        check_eq("starve_rspTag", rspTag, 1);
      end
      next_cycle();
      if (w == 9) reqValid[1] = 1'b0;
    end
    reqValid = '0;
    prio0 = 1'b0;
    next_cycle();

    // Flush over a held response with requester 1 waiting
    set_req(0, SLT_OP, 32'hFFFF_FFFF, 32'd2, 4'd7);
    #4;
    check_eq("fl_grant0", reqReady, 2'b01);
    next_cycle();
    reqValid[0] = 1'b0;
    set_req(1, ADD, 32'd3, 32'd3, 4'd8);
    flush = 1'b1;
    #4;
    check_eq("fl_full_rspValid", rspValid, 2'b01);
    check_eq("fl_full_rspData", rspData, 1);
    check_eq("fl_noGrant", reqReady, 0);
    check_eq("fl_aluOp", aluOperation, 0);
    next_cycle();
    flush = 1'b0;
    #4;
    check_eq("fl_after_rspValid", rspValid, 0);
    check_eq("fl_after_grant1", reqReady, 2'b10);
    next_cycle();
    reqValid = '0;
    #4;
    check_eq("fl_rsp1_valid", rspValid, 2'b10);
    check_eq("fl_rsp1_data", rspData, 6);
    check_eq("fl_rsp1_tag", rspTag, 8);
    next_cycle();

    // Undefined opcode passes through; ALU yields zero
    set_req(0, 4'hF, 32'd3, 32'd4, 4'd9);
    #4;
    check_eq("undef_aluOp", aluOperation, 4'hF);
    next_cycle();
    reqValid = '0;
    #4;
    check_eq("undef_rspData", rspData, 0);
    check_eq("undef_rspZero", rspZero, 1);
    check_eq("undef_rspTag", rspTag, 9);
    next_cycle();

    // Reset while a response is held
    rspReady = 2'b00;
    set_req(0, ADD, 32'd1, 32'd1, 4'd2);
    next_cycle();
    reqValid = '0;
    #4;
    check_eq("rst_pre_rspValid", rspValid, 2'b01);
    check_eq("rst_pre_rspData", rspData, 2);
    reset = 1'b1;
    #1;
    check_eq("rst_rspValid", rspValid, 0);
    check_eq("rst_rspData", rspData, 0);
    check_eq("rst_rspTag", rspTag, 0);
    next_cycle();
    reset = 1'b0;
    rspReady = 2'b11;
    #4;
    check_eq("rst_post_rspValid", rspValid, 0);
    check_eq("rst_post_reqReady", reqReady, 0);
    check_eq("rst_post_aluIn1", aluIn1, 0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
